// File: rtl/common.sv
// Constants shared across the audio path.
package common;
   localparam int unsigned I2S_BITS = 32;
endpackage

// File: rtl/rj_frame_feeder.sv
// Buffers stereo words in a small FIFO and issues one word per RJ frame (start strobe every 2*I2S_BITS clks).
// Build option: define RJ_FEEDER_REPEAT_EN to repeat the last popped word on underrun instead of muting.
module rj_frame_feeder #(
   parameter int unsigned I2S_BITS    = common::I2S_BITS,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned PRIME_LEVEL = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [2*I2S_BITS-1:0]         s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [2*I2S_BITS-1:0]         data,
   output logic                          start,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned WW = 2 * I2S_BITS;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(WW);

   localparam logic [CW-1:0] CNT_LAST  = CW'(WW - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   state_t        state;
   logic [WW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] frame_cnt;
   logic          push;
   logic          boundary;
   logic          pop;

   // boundary marks the edge that raises start, so start lines up with frame_cnt == 0
   always_comb begin
      s_ready  = (state != IDLE) && (level < LVL_FULL);
      push     = s_valid && s_ready;
      boundary = 1'b0;
      if (enable) begin
         unique case (state)
            PRIME:   boundary = (level >= LVL_PRIME);
            RUN:     boundary = (frame_cnt == CNT_LAST);
            default: boundary = 1'b0;
         endcase
      end
      pop = boundary && (level != '0);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         frame_cnt <= '0;
         data      <= '0;
         start     <= 1'b0;
         underrun  <= 1'b0;
      end else if (!enable) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         frame_cnt <= '0;
         data      <= '0;
         start     <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         start    <= boundary;
         underrun <= boundary && (level == '0);

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            data   <= mem[rd_ptr];
         end else if (boundary) begin
`ifdef RJ_FEEDER_REPEAT_EN
            data <= data;
`else
            data <= '0;
`endif
         end

         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         case (state)
            IDLE: begin
               state <= PRIME;
            end
            PRIME: begin
               if (level >= LVL_PRIME) begin
                  state     <= RUN;
                  frame_cnt <= '0;
               end
            end
            RUN: begin
               frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rj_frame_feeder.sv
// Self-checking bench for rj_frame_feeder: directed phases plus randomized traffic against a queue-based frame model.
module tb_rj_frame_feeder;

   localparam int unsigned I2S_BITS    = 32;
   localparam int unsigned FIFO_DEPTH  = 4;
   localparam int unsigned PRIME_LEVEL = 2;
   localparam int unsigned WW          = 2 * I2S_BITS;
   localparam int          FRAME       = 2 * I2S_BITS;
`ifdef RJ_FEEDER_REPEAT_EN
   localparam bit REPEAT = 1'b1;
`else
   localparam bit REPEAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          s_valid;
   logic          s_ready;
   logic          start;
   logic          underrun;
   logic [WW-1:0] s_data;
   logic [WW-1:0] data;
   logic [2:0]    level;

   int checks   = 0;
   int failures = 0;

   // Reference model: words waiting, whether the feeder has been enabled since the last flush,
   // and the clk position inside the current frame (-1 before the first frame).
   logic [WW-1:0] q[$];
   bit            m_armed;
   int            m_pos;
   logic [WW-1:0] m_data;
   bit            m_start;
   bit            m_under;

   always #5 clk = ~clk;

   rj_frame_feeder #(
      .I2S_BITS    (I2S_BITS),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .PRIME_LEVEL (PRIME_LEVEL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .data     (data),
      .start    (start),
      .underrun (underrun),
      .level    (level)
   );

   function automatic logic [WW-1:0] rnd();
      return {$urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      q.delete();
      m_armed = 1'b0;
      m_pos   = -1;
      m_data  = '0;
      m_start = 1'b0;
      m_under = 1'b0;
   endtask

   task automatic model_edge();
      bit push;
      bit frame;
      if (!rst_n || !enable) begin
         m_reset();
         return;
      end
      push  = s_valid && m_armed && (q.size() < FIFO_DEPTH);
      frame = (m_pos == FRAME - 1) || (m_armed && m_pos < 0 && q.size() >= PRIME_LEVEL);
      m_start = frame;
      m_under = frame && (q.size() == 0);
      if (frame) begin
         if (q.size() > 0) m_data = q.pop_front();
         else if (!REPEAT) m_data = '0;
      end
      if (push) q.push_back(s_data);
      if (frame) m_pos = 0;
      else if (m_pos >= 0) m_pos++;
      m_armed = 1'b1;
   endtask

   task automatic tick();
      chk("s_ready", WW'(s_ready), WW'(m_armed && (q.size() < FIFO_DEPTH)));
      model_edge();
      @(posedge clk);
      #1;
      chk("start", WW'(start), WW'(m_start));
      chk("underrun", WW'(underrun), WW'(m_under));
      chk("level", WW'(level), WW'(q.size()));
      if (m_pos >= 0) chk("data", data, m_data);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, data, '0);
      chk({tag, "_start"}, WW'(start), '0);
      chk({tag, "_underrun"}, WW'(underrun), '0);
      chk({tag, "_level"}, WW'(level), '0);
      chk({tag, "_s_ready"}, WW'(s_ready), '0);
   endtask

   initial begin
      int guard;
      rst_n   = 1'b0;
      enable  = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_reset();
      #12;
      check_all_zero("reset");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // two words, then let the FIFO run dry into an underrun
      enable = 1'b1;
      tick();
      s_valid = 1'b1;
      s_data  = rnd();
      tick();
      s_data = rnd();
      tick();
      s_valid = 1'b0;
      tick();
      chk("first_start", WW'(start), WW'(1));
      repeat (3 * FRAME + 8) tick();

      // continuous push: backpressure when full, no gaps in output
      s_valid = 1'b1;
      repeat (6 * FRAME) begin
         s_data = rnd();
         tick();
      end

      // drop enable at frame position 20 with three words buffered
      s_valid = 1'b0;
      guard = 0;
      while (!(m_pos == 20 && q.size() == 3) && guard < 4 * FRAME) begin
         tick();
         guard++;
      end
      chk("reach_pos20_lvl3", WW'(guard < 4 * FRAME), WW'(1));
      enable = 1'b0;
      tick();
      chk("flush_level", WW'(level), '0);
      s_valid = 1'b1;
      repeat (FRAME + 10) begin
         s_data = rnd();
         tick();
      end
      s_valid = 1'b0;

      // re-enable, prime with two words, then push on the same edge as a pop at level 2
      enable = 1'b1;
      tick();
      s_valid = 1'b1;
      s_data  = rnd();
      tick();
      s_data = rnd();
      tick();
      s_valid = 1'b0;
      tick();
      chk("restart_start", WW'(start), WW'(1));
      repeat (4) tick();
      s_valid = 1'b1;
      s_data  = rnd();
      tick();
      s_valid = 1'b0;
      guard = 0;
      while (m_pos != FRAME - 1 && guard < 2 * FRAME) begin
         tick();
         guard++;
      end
      chk("reach_boundary", WW'(guard < 2 * FRAME), WW'(1));
      chk("pre_pushpop_level", WW'(level), WW'(2));
      s_valid = 1'b1;
      s_data  = rnd();
      tick();
      s_valid = 1'b0;
      chk("pushpop_level", WW'(level), WW'(2));
      chk("pushpop_start", WW'(start), WW'(1));
      repeat (3 * FRAME) tick();

      // asynchronous reset in the middle of a frame
      s_valid = 1'b1;
      repeat (FRAME + 30) begin
         s_data = rnd();
         tick();
      end
      #3;
      rst_n = 1'b0;
      m_reset();
      #1;
      check_all_zero("async_rst");
      repeat (2) tick();
      rst_n   = 1'b1;
      s_valid = 1'b0;
      enable  = 1'b0;
      repeat (10) tick();
      enable = 1'b1;
      repeat (20) tick();
      s_valid = 1'b1;
      s_data  = rnd();
      tick();
      s_valid = 1'b0;
      repeat (20) tick();

      // randomized traffic: first mostly fed, then starved
      repeat (1500) begin
         s_valid = ($urandom_range(0, 39) == 0);
         s_data  = rnd();
         if ($urandom_range(0, 999) < 3) enable = ~enable;
         tick();
      end
      enable = 1'b1;
      repeat (1500) begin
         s_valid = ($urandom_range(0, 99) == 0);
         s_data  = rnd();
         if ($urandom_range(0, 999) < 2) enable = ~enable;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rj_frame_feeder.md
RJ_FRAME_FEEDER -- requirements
Module: rj_frame_feeder

Interface
REQ-001 SHALL have parameter: I2S_BITS, from package common, bits per channel slot.
REQ-002 SHALL have parameter: FIFO_DEPTH, 4, stereo words buffered (power of two, >=2).
REQ-003 SHALL have parameter: PRIME_LEVEL, 2, FIFO level required before frame output starts (1..FIFO_DEPTH).
REQ-004 SHALL have port: clk  in  1  sole clock, all flops on rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: enable  in  1  1 = run, 0 = stop and flush.
REQ-007 SHALL have port: s_data  in  2*I2S_BITS  stereo word; high half is left, low half is right.
REQ-008 SHALL have port: s_valid  in  1  s_data valid.
REQ-009 SHALL have port: s_ready  out  1  word accepted on a clk edge where s_valid && s_ready.
REQ-010 SHALL have port: data  out  2*I2S_BITS  frame word to the downstream RJ transceiver.
REQ-011 SHALL have port: start  out  1  one-clk frame strobe to the downstream RJ transceiver.
REQ-012 SHALL have port: underrun  out  1  one-clk pulse, frame issued with FIFO empty.
REQ-013 SHALL have port: level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL hold a FIFO_DEPTH-entry FIFO; s_ready = (state != IDLE) && (level < FIFO_DEPTH).
REQ-015 SHALL use FSM states IDLE, PRIME, RUN.
- IDLE -> PRIME when enable = 1.
- PRIME -> RUN when level >= PRIME_LEVEL.
- Any state -> IDLE when enable = 0.
REQ-016 SHALL, on entry to IDLE, flush the FIFO (level = 0 next cycle) and hold start = 0 and underrun = 0.
REQ-017 SHALL keep a frame counter 0..2*I2S_BITS-1.
- Cleared on entry to RUN.
- Increments every clk in RUN.
- Wraps from 2*I2S_BITS-1 to 0.
REQ-018 SHALL register start = 1 for exactly the clk cycles in RUN where the frame counter = 0, so consecutive start pulses are exactly 2*I2S_BITS clks apart.
REQ-019 SHALL, in the cycle start = 1, present on data the word popped from the FIFO head (pop on the edge that raises start), and hold data constant until the next start.
REQ-020 SHALL, when a frame boundary occurs with the FIFO empty, present data = 0, pulse underrun for that same cycle, and remain in RUN.
REQ-021 SHALL, on a simultaneous push and pop, leave level unchanged and keep word order (FIFO, no loss, no duplication).
REQ-022 SHALL ignore s_data when s_valid = 0 or s_ready = 0.
REQ-023 SHALL, when enable falls mid-frame, abandon the frame immediately; no further start pulse is issued until PRIME completes again.
REQ-024 SHALL have one-clk latency from the pop edge to data/start valid at the outputs (both registered).

Reset
REQ-025 SHALL, while rst_n = 0, force:
- state = IDLE, FIFO empty, level = 0, frame counter = 0;
- data = 0, start = 0, underrun = 0, s_ready = 0.
REQ-026 SHALL, on rst_n assertion mid-frame, clear all state asynchronously; on release, resume from IDLE.

Configuration
REQ-027 SHALL support macro RJ_FEEDER_REPEAT_EN.
- Defined: on underrun, data repeats the last successfully popped word (0 if none popped since reset/IDLE); the underrun pulse is unchanged.
- Undefined: on underrun, data = 0 (mute).

Verification (I2S_BITS = 32, FIFO_DEPTH = 4, PRIME_LEVEL = 2)
REQ-028 SHALL cover: reset release, enable = 1, push words A, B -> RUN entered, start at counter 0 with data = A, next start 64 clks later with data = B.
REQ-029 SHALL cover: push continuously with s_valid = 1 -> s_ready drops when level = 4, rises after each pop; output order A, B, C, D, E with no gaps.
REQ-030 SHALL cover: after A, B only -> third start carries data = 0 and underrun = 1 for one clk (with RJ_FEEDER_REPEAT_EN: data = B).
REQ-031 SHALL cover: enable = 0 at frame counter 20 with level = 3 -> next cycle level = 0, start never asserts; re-enable and push two words -> fresh start, counter from 0.
REQ-032 SHALL cover: push at the same edge as a pop with level = 2 -> level stays 2 and order is preserved.
REQ-033 SHALL cover: rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; after release, no start until enable = 1 and level >= 2.
